// File: rtl/sha3_avmm_sequencer.sv
// rtl/sha3_avmm_sequencer.sv - Avalon-MM master that loads rate blocks into the SHA3 wrapper and streams the digest out
module sha3_avmm_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int BLOCK_WORDS  = 34,
    parameter int DIGEST_WORDS = 8,
    parameter int REG_CTRL     = 0,
    parameter int REG_STATUS   = 1,
    parameter int REG_DATA     = 2,
    parameter int REG_DIGEST   = 8,
    parameter int POLL_MAX     = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       msg_data,
    input  logic              msg_valid,
    input  logic              msg_last,
    output logic              msg_ready,
    output logic [31:0]       dig_data,
    output logic              dig_valid,
    output logic              dig_last,
    input  logic              dig_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              err
);

    localparam int WC_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int DI_W = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam int PC_W = $clog2(POLL_MAX + 1);

    localparam logic [WC_W-1:0]   WORD_LAST = WC_W'(BLOCK_WORDS - 1);
    localparam logic [DI_W-1:0]   IDX_LAST  = DI_W'(DIGEST_WORDS - 1);
    localparam logic [PC_W-1:0]   POLL_LAST = PC_W'(POLL_MAX - 1);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_DATA    = ADDR_W'(REG_DATA);
    localparam logic [ADDR_W-1:0] A_DIGEST  = ADDR_W'(REG_DIGEST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_LOAD,
        S_KICK,
        S_POLL,
        S_DIG_RD,
        S_DIG_OUT,
        S_ERR
    } state_t;

    state_t          state;
    logic [WC_W-1:0] word_cnt;
    logic [DI_W-1:0] dig_idx;
    logic [PC_W-1:0] poll_cnt;
    logic            last_blk;
    logic            accept;
    logic            xfer_done;
    logic            status_hit;

    assign accept     = msg_valid & msg_ready;
    assign xfer_done  = (avm_read | avm_write) & ~avm_waitrequest;
    assign status_hit = last_blk ? avm_readdata[1] : avm_readdata[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            word_cnt      <= '0;
            dig_idx       <= '0;
            poll_cnt      <= '0;
            last_blk      <= 1'b0;
            msg_ready     <= 1'b0;
            dig_data      <= '0;
            dig_valid     <= 1'b0;
            dig_last      <= 1'b0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        msg_ready <= 1'b0;
                        busy      <= 1'b1;
                        // A last flag anywhere but the final rate word means a broken message
                        if (msg_last && (word_cnt != WORD_LAST)) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            last_blk      <= msg_last;
                            avm_write     <= 1'b1;
                            avm_address   <= A_DATA;
                            avm_writedata <= msg_data;
                            state         <= S_WR_DATA;
                        end
                    end else begin
                        msg_ready <= 1'b1;
                    end
                end

                S_WR_DATA: begin
                    if (xfer_done) begin
                        avm_write <= 1'b0;
                        if (word_cnt == WORD_LAST) begin
                            word_cnt <= '0;
                            state    <= S_KICK;
                        end else begin
                            word_cnt  <= word_cnt + 1'b1;
                            msg_ready <= 1'b1;
                            state     <= S_LOAD;
                        end
                    end
                end

                // Command states after a completion leave one idle cycle before the next command
                S_KICK: begin
                    if (!avm_write) begin
                        avm_write     <= 1'b1;
                        avm_address   <= A_CTRL;
                        avm_writedata <= {30'b0, last_blk, 1'b1};
                    end else if (xfer_done) begin
                        avm_write <= 1'b0;
                        poll_cnt  <= '0;
                        state     <= S_POLL;
                    end
                end

                S_POLL: begin
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= A_STATUS;
                    end else if (xfer_done) begin
                        avm_read <= 1'b0;
                        poll_cnt <= poll_cnt + 1'b1;
                        if (status_hit) begin
                            poll_cnt <= '0;
                            if (last_blk) begin
                                dig_idx <= '0;
                                state   <= S_DIG_RD;
                            end else begin
                                msg_ready <= 1'b1;
                                state     <= S_LOAD;
                            end
                        end else if (poll_cnt == POLL_LAST) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end

                S_DIG_RD: begin
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= A_DIGEST + ADDR_W'(dig_idx);
                    end else if (xfer_done) begin
                        avm_read  <= 1'b0;
                        dig_data  <= avm_readdata;
                        dig_valid <= 1'b1;
                        dig_last  <= (dig_idx == IDX_LAST);
                        state     <= S_DIG_OUT;
                    end
                end

                S_DIG_OUT: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        dig_last  <= 1'b0;
                        if (dig_idx == IDX_LAST) begin
                            busy      <= 1'b0;
                            msg_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            dig_idx <= dig_idx + 1'b1;
                            state   <= S_DIG_RD;
                        end
                    end
                end

                S_ERR: begin
                    msg_ready <= 1'b0;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                    dig_valid <= 1'b0;
                    dig_last  <= 1'b0;
                    busy      <= 1'b1;
                    err       <= 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_avmm_sequencer.sv
// tb/tb_sha3_avmm_sequencer.sv - scoreboard bench for sha3_avmm_sequencer against a wrapper slave model
module tb_sha3_avmm_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_last;
    logic        msg_ready;
    logic [31:0] dig_data;
    logic        dig_valid;
    logic        dig_last;
    logic        dig_ready;
    logic [7:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        err;

    sha3_avmm_sequencer dut (
        .clk(clk), .reset(reset),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_last(dig_last), .dig_ready(dig_ready),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] EMPTY_DIG [8] = '{32'ha7ffc6f8, 32'hbf1ed766, 32'h51c14756, 32'ha061d662,
                                              32'hf580ff4d, 32'he43b49fa, 32'h82d80a4b, 32'h80f8434a};
    localparam logic [31:0] ALT_DIG [8]   = '{32'h3a985da7, 32'h4fe225b2, 32'h045c172d, 32'h6bd390bd,
                                              32'h855f086e, 32'h3e9d525b, 32'h46bfe245, 32'h11431532};

    int          checks = 0;
    int          errors = 0;
    logic [40:0] exp_tx[$];     // {is_write, address, writedata}
    logic [32:0] exp_dig[$];    // {last, word}
    logic [31:0] dig_tbl [8];
    bit          stall_en   = 0;
    bit          force_wait = 0;
    int          poll_delay_cfg = 0;
    int          status_reads   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_msg_ready"}, msg_ready, 0);
        chk({tag, "_dig_valid"}, dig_valid, 0);
        chk({tag, "_dig_last"}, dig_last, 0);
        chk({tag, "_dig_data"}, dig_data, 0);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_write"}, avm_write, 0);
        chk({tag, "_avm_address"}, avm_address, 0);
        chk({tag, "_avm_writedata"}, avm_writedata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Wrapper slave model: waitrequest insertion, status bits after a set number of polls, digest table
    initial begin : slave
        int  wcnt;
        int  poll_left;
        int  a;
        bit  active;
        bit  slv_last;
        wcnt = 0; poll_left = 0; active = 0; slv_last = 0;
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0; wcnt = 0; poll_left = 0;
                avm_waitrequest = 1'b0;
            end else if (avm_read || avm_write) begin
                if (!active) begin
                    active = 1;
                    wcnt   = stall_en ? int'($urandom_range(0, 5)) : 0;
                end
                if (force_wait) begin
                    avm_waitrequest = 1'b1;
                end else if (wcnt > 0) begin
                    avm_waitrequest = 1'b1;
                    wcnt--;
                end else begin
                    avm_waitrequest = 1'b0;
                    active = 0;
                    a = int'(avm_address);
                    if (avm_write && a == 0) begin
                        slv_last     = avm_writedata[1];
                        poll_left    = poll_delay_cfg;
                        status_reads = 0;
                    end
                    if (avm_read) begin
                        if (a == 1) begin
                            status_reads++;
                            if (poll_left > 0) begin
                                avm_readdata = '0;
                                poll_left--;
                            end else begin
                                avm_readdata = slv_last ? 32'd2 : 32'd1;
                            end
                        end else if (a >= 8 && a < 16) begin
                            avm_readdata = dig_tbl[a-8];
                        end else begin
                            avm_readdata = 32'hdeadbeef;
                        end
                    end
                end
            end else begin
                avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    initial begin : sink
        dig_ready = 1'b1;
        forever begin
            @(negedge clk);
            dig_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Scoreboard monitor: pops on every completed transfer and every digest handshake
    initial begin : monitor
        logic [40:0] e;
        logic [32:0] d;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && (avm_read || avm_write) && !avm_waitrequest) begin
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL avm_unexpected: got wr=%0b addr=%0h data=%0h expected no transfer",
                             avm_write, avm_address, avm_writedata);
                end else begin
                    e = exp_tx.pop_front();
                    chk("avm_cmd_addr", {avm_write, avm_address}, {e[40], e[39:32]});
                    if (e[40]) chk("avm_wdata", avm_writedata, e[31:0]);
                end
            end
            if (!reset && dig_valid && dig_ready) begin
                if (exp_dig.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dig_unexpected: got %0h expected no digest word", dig_data);
                end else begin
                    d = exp_dig.pop_front();
                    chk("dig_word", {dig_last, dig_data}, d);
                end
            end
        end
    end

    // Stall stability and read/write exclusivity
    initial begin : stability
        bit          cmd_hold;
        bit          dig_hold;
        logic [41:0] cmd_snap;
        logic [32:0] dig_snap;
        cmd_hold = 0; dig_hold = 0; cmd_snap = '0; dig_snap = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                cmd_hold = 0;
                dig_hold = 0;
            end else begin
                if (cmd_hold) chk("cmd_stable", {avm_read, avm_write, avm_address, avm_writedata}, cmd_snap);
                if (dig_hold) chk("dig_stable", {dig_valid, dig_data}, {1'b1, dig_snap[31:0]});
                if (avm_read && avm_write) chk("rd_wr_exclusive", {avm_read, avm_write}, 2'b10);
                cmd_hold = (avm_read || avm_write) && avm_waitrequest;
                cmd_snap = {avm_read, avm_write, avm_address, avm_writedata};
                dig_hold = dig_valid && !dig_ready;
                dig_snap = {dig_last, dig_data};
            end
        end
    end

    function automatic logic [31:0] msg_word(input int kind, input int i);
        logic [7:0]  k;
        logic [15:0] ii;
        k  = 8'(kind);
        ii = 16'(i);
        if (kind == 0) return (i == 0) ? 32'h00000006 : (i == 33) ? 32'h80000000 : 32'h0;
        return {k, 8'h5a, ii};
    endfunction

    task automatic send_word(input logic [31:0] w, input logic lst);
        int n;
        msg_data  = w;
        msg_last  = lst;
        msg_valid = 1'b1;
        n = 0;
        while (!msg_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("msg_ready_timeout", 0, 1);
        @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    // pdelay < 0: status never sets; bad_at >= 0: msg_last placed on that word, which is then not written
    task automatic run_block(input int kind, input bit is_last, input int pdelay, input int bad_at);
        int npoll;
        int nwords;
        nwords = (bad_at >= 0) ? bad_at + 1 : 34;
        for (int i = 0; i < nwords; i++)
            if (i != bad_at) exp_tx.push_back({1'b1, 8'd2, msg_word(kind, i)});
        if (bad_at < 0) begin
            exp_tx.push_back({1'b1, 8'd0, 30'b0, is_last, 1'b1});
            npoll = (pdelay < 0) ? 1023 : pdelay + 1;
            poll_delay_cfg = (pdelay < 0) ? 1000000 : pdelay;
            for (int i = 0; i < npoll; i++) exp_tx.push_back({1'b0, 8'd1, 32'h0});
            if (is_last)
                for (int i = 0; i < 8; i++) begin
                    exp_tx.push_back({1'b0, 8'(8 + i), 32'h0});
                    exp_dig.push_back({(i == 7), dig_tbl[i]});
                end
        end
        for (int i = 0; i < nwords; i++)
            send_word(msg_word(kind, i), (bad_at >= 0) ? (i == bad_at) : (is_last && i == 33));
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_dig.size() != 0 || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drained"}, (n < 20000), 1);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        force_wait = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        int n;
        reset = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0;
        dig_tbl = EMPTY_DIG;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("msg_ready_after_reset", msg_ready, 1);
        chk("busy_after_reset", busy, 0);

        // Single padded-empty block, no stalls
        run_block(0, 1, 2, -1);
        wait_idle("single");
        chk("single_err", err, 0);
        chk("single_ready", msg_ready, 1);

        // Two blocks: first polls bit0, second polls bit1
        dig_tbl = ALT_DIG;
        run_block(1, 0, 1, -1);
        run_block(2, 1, 1, -1);
        wait_idle("two_block");

        // Same single block with random waitrequest and digest backpressure
        stall_en = 1;
        dig_tbl  = EMPTY_DIG;
        run_block(0, 1, 3, -1);
        wait_idle("stall");
        stall_en = 0;
        @(negedge clk);

        // msg_last on word 10
        run_block(1, 0, 0, 10);
        n = 0;
        while (!err && n < 2) begin
            @(negedge clk);
            n++;
        end
        chk("misplaced_err", err, 1);
        repeat (20) @(negedge clk);
        chk("misplaced_err_sticky", err, 1);
        chk("misplaced_busy", busy, 1);
        chk("misplaced_ready", msg_ready, 0);
        chk("misplaced_no_ctrl", exp_tx.size(), 0);
        do_reset();
        chk("misplaced_err_cleared", err, 0);

        // Status never sets: timeout after exactly 1023 reads
        run_block(1, 0, -1, -1);
        n = 0;
        while (!err && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("poll_timeout_err", err, 1);
        repeat (10) @(negedge clk);
        chk("poll_timeout_reads", status_reads, 1023);
        chk("poll_timeout_queue", exp_tx.size(), 0);
        chk("poll_timeout_busy", busy, 1);
        do_reset();

        // Reset while word 20 is stalled by waitrequest
        for (int i = 0; i < 20; i++) exp_tx.push_back({1'b1, 8'd2, msg_word(1, i)});
        for (int i = 0; i < 20; i++) send_word(msg_word(1, i), 1'b0);
        force_wait = 1;
        send_word(msg_word(1, 20), 1'b0);
        chk("midop_write_pending", {avm_write, avm_waitrequest}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midop");
        force_wait = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("midop_queue", exp_tx.size(), 0);
        dig_tbl = EMPTY_DIG;
        run_block(0, 1, 2, -1);
        wait_idle("after_midop");
        chk("after_midop_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
